// File: rtl/distribute_1x2_one_hot_comb_pkg.sv
// Shared NoC helpers for the distribute/reduce nodes: command-width derivation
// and the filler value driven on idle data lanes.
package distribute_1x2_one_hot_comb_pkg;

  // Filler bit for idle data lanes; replicate to the lane width at the use site.
  localparam logic DUMMY_BIT = 1'b0;

  // The last node in the chain still drives a 1-bit (always zero) command.
  function automatic int out_cmd_width(input int in_width);
    return (in_width == 1) ? 1 : in_width - 1;
  endfunction

endpackage

// File: rtl/distribute_1x2_one_hot_comb_noc_out_reg.sv
// Parameterized-width output register that clears to zero on an asynchronous
// active-high reset.
module noc_out_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/distribute_1x2_one_hot_comb.sv
// 1-in / 2-out one-hot multicast distribute node: bit 0 of the command drops data
// locally, the remaining bits forward data and the shifted command downstream.
module distribute_1x2_one_hot_comb
  import distribute_1x2_one_hot_comb_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int IN_COMMAND_WIDTH = 2,
  parameter int OUTPUT_REG       = 0,
  localparam int OUT_COMMAND_WIDTH = out_cmd_width(IN_COMMAND_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_valid,
  input  logic [DATA_WIDTH-1:0]        i_data_bus,
  input  logic                         i_en,
  input  logic [IN_COMMAND_WIDTH-1:0]  i_cmd,
  output logic [1:0]                   o_valid,
  output logic [2*DATA_WIDTH-1:0]      o_data_bus,
  output logic [OUT_COMMAND_WIDTH-1:0] o_cmd
);

  localparam int PACK_WIDTH = 2 + 2 * DATA_WIDTH + OUT_COMMAND_WIDTH;

  logic                         go;
  logic                         local_valid;
  logic [DATA_WIDTH-1:0]        local_data;
  logic                         fwd_valid;
  logic [DATA_WIDTH-1:0]        fwd_data;
  logic [OUT_COMMAND_WIDTH-1:0] fwd_cmd;
  logic [PACK_WIDTH-1:0]        out_next;
  logic [PACK_WIDTH-1:0]        out_bus;

  assign go          = i_valid & i_en;
  assign local_valid = go & i_cmd[0];
  assign local_data  = local_valid ? i_data_bus : {DATA_WIDTH{DUMMY_BIT}};

  generate
    if (IN_COMMAND_WIDTH > 1) begin : g_forward
      assign fwd_valid = go & (|i_cmd[IN_COMMAND_WIDTH-1:1]);
      assign fwd_cmd   = fwd_valid ? i_cmd[IN_COMMAND_WIDTH-1:1] : '0;
    end else begin : g_last_stage
      // End of the chain: nothing downstream to forward to.
      assign fwd_valid = 1'b0;
      assign fwd_cmd   = '0;
    end
  endgenerate

  assign fwd_data = fwd_valid ? i_data_bus : {DATA_WIDTH{DUMMY_BIT}};

  assign out_next = {fwd_cmd, fwd_data, local_data, fwd_valid, local_valid};

  generate
    if (OUTPUT_REG != 0) begin : g_out_reg
      noc_out_reg #(
        .WIDTH (PACK_WIDTH)
      ) u_out_reg (
        .clk (clk),
        .rst (rst),
        .d   (out_next),
        .q   (out_bus)
      );
    end else begin : g_out_comb
      // clk/rst are only meaningful for the registered variant.
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst};
      assign out_bus = out_next;
    end
  endgenerate

  assign {o_cmd, o_data_bus, o_valid} = out_bus;

endmodule

// File: tb/tb_distribute_1x2_one_hot_comb.sv
// Scoreboard bench: three node variants (N=2 comb, N=1 comb, N=2 registered) share
// one stimulus stream; expected outputs are queued at drive time and popped on output.
module tb_distribute_1x2_one_hot_comb;

  typedef struct packed {
    logic [1:0]  valid;
    logic [63:0] data;
    logic        cmd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_en = 1'b0;
  logic [1:0]  i_cmd = 2'b00;
  logic [31:0] i_data = 32'h0;
  logic [0:0]  i_cmd1;

  logic [1:0]  c2_valid, c1_valid, r2_valid;
  logic [63:0] c2_data,  c1_data,  r2_data;
  logic [0:0]  c2_cmd,   c1_cmd,   r2_cmd;

  int checks = 0;
  int errors = 0;

  exp_t q_c2[$];
  exp_t q_c1[$];
  exp_t q_r2[$];
  exp_t last_r2;

  assign i_cmd1 = i_cmd[0:0];

  always #5 clk = ~clk;

  distribute_1x2_one_hot_comb #(.DATA_WIDTH(32), .IN_COMMAND_WIDTH(2), .OUTPUT_REG(0)) u_c2 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data), .i_en(i_en),
    .i_cmd(i_cmd), .o_valid(c2_valid), .o_data_bus(c2_data), .o_cmd(c2_cmd));

  distribute_1x2_one_hot_comb #(.DATA_WIDTH(32), .IN_COMMAND_WIDTH(1), .OUTPUT_REG(0)) u_c1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data), .i_en(i_en),
    .i_cmd(i_cmd1), .o_valid(c1_valid), .o_data_bus(c1_data), .o_cmd(c1_cmd));

  distribute_1x2_one_hot_comb #(.DATA_WIDTH(32), .IN_COMMAND_WIDTH(2), .OUTPUT_REG(1)) u_r2 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data), .i_en(i_en),
    .i_cmd(i_cmd), .o_valid(r2_valid), .o_data_bus(r2_data), .o_cmd(r2_cmd));

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of a node with n command bits (n = 1 or 2).
  function automatic exp_t model(input int n, input logic v, input logic en,
                                 input logic [1:0] cmd, input logic [31:0] d);
    exp_t e;
    logic go, lv, fv;
    go = v & en;
    lv = go & cmd[0];
    fv = (n > 1) ? (go & cmd[1]) : 1'b0;
    e.valid = {fv, lv};
    e.data  = {(fv ? d : 32'h0), (lv ? d : 32'h0)};
    e.cmd   = (n > 1) ? (fv & cmd[1]) : 1'b0;
    return e;
  endfunction

  task automatic cmp(input string tag, input exp_t e,
                     input logic [1:0] v, input logic [63:0] d, input logic [0:0] c);
    check_eq({tag, ".valid"}, {62'h0, v}, {62'h0, e.valid});
    check_eq({tag, ".data"}, d, e.data);
    check_eq({tag, ".cmd"}, {63'h0, c}, {63'h0, e.cmd});
  endtask

  task automatic step(input logic v, input logic en, input logic [1:0] cmd, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    i_valid = v; i_en = en; i_cmd = cmd; i_data = d;
    q_c2.push_back(model(2, v, en, cmd, d));
    q_c1.push_back(model(1, v, en, cmd, d));
    q_r2.push_back(model(2, v, en, cmd, d));
    #1;
    e = q_c2.pop_front(); cmp("comb_n2", e, c2_valid, c2_data, c2_cmd);
    e = q_c1.pop_front(); cmp("comb_n1", e, c1_valid, c1_data, c1_cmd);
    cmp("reg_hold", last_r2, r2_valid, r2_data, r2_cmd);
    @(posedge clk); #1;
    e = q_r2.pop_front(); cmp("reg_n2", e, r2_valid, r2_data, r2_cmd);
    last_r2 = e;
    $display("txn v=%0b en=%0b cmd=%b data=%h -> comb=%b reg=%b", v, en, cmd, d, c2_valid, r2_valid);
  endtask

  initial begin
    exp_t zero;
    exp_t e;
    zero = '0;
    #1 rst = 1'b1;
    #1 cmp("reset_async", zero, r2_valid, r2_data, r2_cmd);
    repeat (2) @(posedge clk);
    #1 cmp("reset_hold", zero, r2_valid, r2_data, r2_cmd);
    @(negedge clk) rst = 1'b0;
    last_r2 = zero;

    step(1'b1, 1'b1, 2'b01, 32'h1111_1111);
    step(1'b1, 1'b1, 2'b10, 32'h2222_2222);
    step(1'b1, 1'b1, 2'b11, 32'h5555_5555);
    step(1'b0, 1'b1, 2'b11, 32'h6666_6666);
    step(1'b1, 1'b0, 2'b11, 32'h7777_7777);
    step(1'b1, 1'b1, 2'b00, 32'h8888_8888);
    step(1'b1, 1'b1, 2'b11, 32'hA5A5_A5A5);
    for (int i = 0; i < 24; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 32'($urandom));
    end

    // Reset in the middle of a transfer: outputs must clear before any edge.
    step(1'b1, 1'b1, 2'b11, 32'hA5A5_A5A5);
    @(negedge clk);
    i_valid = 1'b1; i_en = 1'b1; i_cmd = 2'b01; i_data = 32'h1234_5678;
    #1 rst = 1'b1;
    #1 cmp("rst_mid", zero, r2_valid, r2_data, r2_cmd);
    @(posedge clk); #1 cmp("rst_held", zero, r2_valid, r2_data, r2_cmd);
    @(negedge clk) rst = 1'b0;
    #1 cmp("rst_released", zero, r2_valid, r2_data, r2_cmd);
    @(posedge clk);
    #1;
    e = model(2, 1'b1, 1'b1, 2'b01, 32'h1234_5678);
    cmp("first_capture", e, r2_valid, r2_data, r2_cmd);
    $display("txn reset release capture -> reg=%b data=%h", r2_valid, r2_data);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
